// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver feeding the signal buffer: one data_rdy pulse per good byte,
// data_end when a frame fills up or when the line goes idle after a partial frame.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_LEN    = 256,
  parameter int IDLE_BITS    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] quant_byte,
  output logic       data_rdy,
  output logic       data_end,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW         = $clog2(CLKS_PER_BIT);
  localparam int CW         = $clog2(FRAME_LEN + 1);
  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int IW         = $clog2(IDLE_LIMIT + 1);

  localparam logic [TW-1:0] T_HALF    = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rxs_q, rxs_prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    quant_q, quant_d;
  logic          rdy_q, rdy_d;
  logic          end_q, end_d;
  logic          err_q, err_d;
  logic          fall;

  assign fall = rxs_prev_q & ~rxs_q;

  // State and datapath registers; synchronizer and edge history idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      quant_q    <= '0;
      rdy_q      <= 1'b0;
      end_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      quant_q    <= quant_d;
      rdy_q      <= rdy_d;
      end_q      <= end_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    quant_d   = quant_q;
    rdy_d     = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (fall) begin
          state_d = S_START;
          idle_d  = '0;
        end else if (cnt_q != '0) begin
          // Partial frame left hanging: flush it once the line has been quiet long enough.
          if (idle_q == IDLE_LAST) begin
            end_d  = 1'b1;
            cnt_d  = '0;
            idle_d = '0;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (timer_q == T_LAST) begin
          timer_d   = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_STOP: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
          if (rxs_q) begin
            quant_d = shift_q;
            rdy_d   = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              end_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    quant_byte = quant_q;
    data_rdy   = rdy_q;
    data_end   = end_q;
    frame_err  = err_q;
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed vector table, multi-cycle corner sequences and
// randomized bytes checked against an event-level frame model.
module tb_uart_frame_rx;

  localparam int CPB = 8;
  localparam int FL  = 4;
  localparam int IB  = 3;

  localparam int K_RDY    = 0;
  localparam int K_RDYEND = 1;
  localparam int K_END    = 2;
  localparam int K_ERR    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] quant_byte;
  logic       data_rdy, data_end, frame_err, busy;

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .FRAME_LEN(FL), .IDLE_BITS(IB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .quant_byte(quant_byte),
    .data_rdy  (data_rdy),
    .data_end  (data_end),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
    bit         bfall;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    int         exp_kind;
    bit         exp_idle_end;
    logic [7:0] exp_quant;
  } vec_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  pulse_viol = 0;
  bit  prev_rdy = 0, prev_end = 0, prev_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: one record per output pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if ((data_rdy && prev_rdy) || (data_end && prev_end) || (data_rdy && frame_err))
        pulse_viol <= pulse_viol + 1;
      if (data_rdy)
        obs_q.push_back(ev_t'{kind: (data_end ? K_RDYEND : K_RDY), data: quant_byte,
                              cyc: cyc, bfall: (prev_busy && !busy)});
      else if (data_end)
        obs_q.push_back(ev_t'{kind: K_END, data: quant_byte, cyc: cyc, bfall: 1'b0});
      if (frame_err)
        obs_q.push_back(ev_t'{kind: K_ERR, data: quant_byte, cyc: cyc, bfall: 1'b0});
    end
    prev_rdy  <= data_rdy;
    prev_end  <= data_end;
    prev_busy <= busy;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Called at posedge+1; leaves at posedge+1.
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) drive(fr[i], CPB);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int gap);
    send_bits(d, stop, 10);
    drive(1'b1, gap);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    exp_q.push_back(ev_t'{kind: kind, data: d, cyc: 0, bfall: 1'b0});
  endtask

  task automatic compare_events(input string tag);
    chk({tag, " event count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        $display("%s ev%0d kind=%0d data=%02h (want kind=%0d data=%02h) cyc=%0d",
                 tag, i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data, obs_q[i].cyc);
        chk($sformatf("%s ev%0d kind", tag, i), obs_q[i].kind, exp_q[i].kind);
        chk($sformatf("%s ev%0d data", tag, i), int'(obs_q[i].data), int'(exp_q[i].data));
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t       vecs[12];
    int         mcount;
    logic [7:0] mlast;
    logic [7:0] d;
    bit         ok;
    bit         long_gap;
    int         gap;

    vecs[0]  = '{8'hA5, 1'b1, 50, K_RDY,    1'b1, 8'hA5};
    vecs[1]  = '{8'h01, 1'b1,  0, K_RDY,    1'b0, 8'h01};
    vecs[2]  = '{8'h02, 1'b1,  0, K_RDY,    1'b0, 8'h02};
    vecs[3]  = '{8'h03, 1'b1,  0, K_RDY,    1'b0, 8'h03};
    vecs[4]  = '{8'hFF, 1'b1, 50, K_RDYEND, 1'b0, 8'hFF};
    vecs[5]  = '{8'h55, 1'b0, 50, K_ERR,    1'b0, 8'hFF};
    vecs[6]  = '{8'h66, 1'b1, 50, K_RDY,    1'b1, 8'h66};
    vecs[7]  = '{8'h11, 1'b1,  0, K_RDY,    1'b0, 8'h11};
    vecs[8]  = '{8'h55, 1'b0, 12, K_ERR,    1'b0, 8'h11};
    vecs[9]  = '{8'h22, 1'b1,  0, K_RDY,    1'b0, 8'h22};
    vecs[10] = '{8'h33, 1'b1,  0, K_RDY,    1'b0, 8'h33};
    vecs[11] = '{8'h44, 1'b1, 50, K_RDYEND, 1'b0, 8'h44};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset quant_byte", int'(quant_byte), 0);
    chk("reset data_rdy", int'(data_rdy), 0);
    chk("reset data_end", int'(data_end), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 10);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].data, vecs[i].stop_ok, vecs[i].gap);
      expect_ev(vecs[i].exp_kind, vecs[i].exp_quant);
      if (vecs[i].exp_idle_end) expect_ev(K_END, vecs[i].exp_quant);
    end
    drive(1'b1, 30);
    chk("vec final quant_byte", int'(quant_byte), 8'h44);
    chk("vec busy idle", int'(busy), 0);
    compare_events("vec");

    // Idle flush after partial frame: data_end alone 24 cycles after IDLE entry
    send(8'h10, 1'b1, 0);
    send(8'h20, 1'b1, 0);
    drive(1'b1, 120);
    if (obs_q.size() == 3) begin
      chk("flush delay from idle entry", obs_q[2].cyc - obs_q[1].cyc, IB * CPB);
      chk("rdy on idle entry", int'(obs_q[1].bfall), 1);
    end
    expect_ev(K_RDY, 8'h10);
    expect_ev(K_RDY, 8'h20);
    expect_ev(K_END, 8'h20);
    compare_events("flush");

    // Glitch shorter than half a bit
    drive(1'b0, 3);
    drive(1'b1, 30);
    chk("glitch busy low", int'(busy), 0);
    compare_events("glitch");

    // Reset during bit 3 of 0x3C after one counted byte
    send(8'h77, 1'b1, 0);
    expect_ev(K_RDY, 8'h77);
    send_bits(8'h3C, 1'b1, 4);
    drive(1'b1, CPB / 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid-reset quant_byte", int'(quant_byte), 0);
    chk("mid-reset data_rdy", int'(data_rdy), 0);
    chk("mid-reset data_end", int'(data_end), 0);
    chk("mid-reset frame_err", int'(frame_err), 0);
    chk("mid-reset busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 10);
    send(8'hC3, 1'b1, 0);
    send(8'hC4, 1'b1, 0);
    send(8'hC5, 1'b1, 0);
    send(8'hC6, 1'b1, 50);
    expect_ev(K_RDY, 8'hC3);
    expect_ev(K_RDY, 8'hC4);
    expect_ev(K_RDY, 8'hC5);
    expect_ev(K_RDYEND, 8'hC6);
    compare_events("rstmid");

    // Randomized bytes against a frame-level model
    mcount = 0;
    mlast  = 8'hC6;
    for (int n = 0; n < 40; n++) begin
      d        = 8'($urandom);
      ok       = ($urandom_range(0, 99) < 85);
      long_gap = ($urandom_range(0, 3) == 0);
      if (long_gap)  gap = $urandom_range(40, 60);
      else if (ok)   gap = $urandom_range(0, 12);
      else           gap = $urandom_range(10, 14);
      send(d, ok, gap);
      if (ok) begin
        mlast  = d;
        mcount = mcount + 1;
        if (mcount == FL) begin
          expect_ev(K_RDYEND, d);
          mcount = 0;
        end else begin
          expect_ev(K_RDY, d);
        end
      end else begin
        expect_ev(K_ERR, mlast);
      end
      if (long_gap && mcount > 0) begin
        expect_ev(K_END, mlast);
        mcount = 0;
      end
    end
    drive(1'b1, 60);
    compare_events("rand");

    chk("pulse width/overlap violations", pulse_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
